// File: rtl/hifi4_iram1_arbiter_if.sv
// Signal bundle between the core/DMA requesters, the IRAM1 arbiter and the iram1 memory wrapper.
// master = requesters plus memory side, slave = arbiter.
interface hifi4_iram1_arbiter_if;
  logic         CoreEn;
  logic         CoreWr;
  logic [11:0]  CoreAddr;
  logic [3:0]   CoreWordEn;
  logic [127:0] CoreWrData;
  logic         CoreBusy;
  logic         CoreRdValid;
  logic [127:0] CoreRdData;

  logic         DmaReq;
  logic         DmaWr;
  logic [11:0]  DmaAddr;
  logic [3:0]   DmaWordEn;
  logic [127:0] DmaWrData;
  logic         DmaGnt;
  logic         DmaRdValid;
  logic [127:0] DmaRdData;

  logic         IRam1En;
  logic         IRam1Wr;
  logic [11:0]  IRam1Addr;
  logic [3:0]   IRam1WordEn;
  logic [127:0] IRam1WrData;
  logic [127:0] IRam1Data;

  modport slave (
    input  CoreEn, CoreWr, CoreAddr, CoreWordEn, CoreWrData,
    output CoreBusy, CoreRdValid, CoreRdData,
    input  DmaReq, DmaWr, DmaAddr, DmaWordEn, DmaWrData,
    output DmaGnt, DmaRdValid, DmaRdData,
    output IRam1En, IRam1Wr, IRam1Addr, IRam1WordEn, IRam1WrData,
    input  IRam1Data
  );

  modport master (
    output CoreEn, CoreWr, CoreAddr, CoreWordEn, CoreWrData,
    input  CoreBusy, CoreRdValid, CoreRdData,
    output DmaReq, DmaWr, DmaAddr, DmaWordEn, DmaWrData,
    input  DmaGnt, DmaRdValid, DmaRdData,
    input  IRam1En, IRam1Wr, IRam1Addr, IRam1WordEn, IRam1WrData,
    output IRam1Data
  );
endinterface

// File: rtl/hifi4_iram1_arbiter.sv
// Core/DMA arbiter for the single-port IRAM1: fixed core priority with a DMA starvation guard,
// plus a read-return tag pipe that routes IRam1Data back to whichever requester issued the read.
module hifi4_iram1_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int RD_LAT       = 2
) (
  input logic                  CLK,
  input logic                  Reset,
  hifi4_iram1_arbiter_if.slave bus
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic                   force_dma;
  logic                   core_win;
  logic                   dma_win;
  logic [3:0]             starve_cnt;
  logic [3:0]             starve_cnt_nxt;
  logic [RD_LAT-1:0][1:0] rd_pipe;

  always_comb begin
    force_dma = bus.DmaReq && (starve_cnt == LIMIT);
    core_win  = bus.CoreEn && !force_dma;
    dma_win   = bus.DmaReq && !core_win;
  end

  assign bus.CoreBusy = bus.CoreEn && !core_win;
  assign bus.DmaGnt   = dma_win;

  always_comb begin
    bus.IRam1En     = 1'b0;
    bus.IRam1Wr     = 1'b0;
    bus.IRam1Addr   = '0;
    bus.IRam1WordEn = '0;
    bus.IRam1WrData = '0;
    if (core_win) begin
      bus.IRam1En     = 1'b1;
      bus.IRam1Wr     = bus.CoreWr;
      bus.IRam1Addr   = bus.CoreAddr;
      bus.IRam1WordEn = bus.CoreWordEn;
      bus.IRam1WrData = bus.CoreWrData;
    end else if (dma_win) begin
      bus.IRam1En     = 1'b1;
      bus.IRam1Wr     = bus.DmaWr;
      bus.IRam1Addr   = bus.DmaAddr;
      bus.IRam1WordEn = bus.DmaWordEn;
      bus.IRam1WrData = bus.DmaWrData;
    end
  end

  // Counts consecutive cycles a pending DMA request loses; any grant or dropped request restarts it.
  always_comb begin
    starve_cnt_nxt = '0;
    if (bus.DmaReq && !dma_win)
      starve_cnt_nxt = (starve_cnt >= LIMIT) ? LIMIT : starve_cnt + 4'd1;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      starve_cnt <= '0;
      rd_pipe    <= '0;
    end else begin
      starve_cnt <= starve_cnt_nxt;
      rd_pipe[0] <= {core_win && !bus.CoreWr, dma_win && !bus.DmaWr};
      for (int i = 1; i < RD_LAT; i++)
        rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign bus.CoreRdValid = rd_pipe[RD_LAT-1][1];
  assign bus.DmaRdValid  = rd_pipe[RD_LAT-1][0];
  assign bus.CoreRdData  = bus.CoreRdValid ? bus.IRam1Data : '0;
  assign bus.DmaRdData   = bus.DmaRdValid  ? bus.IRam1Data : '0;

endmodule
